data_ram_arbiter: RTL and testbench

- Shares the single-port `data_ram` between two masters: the CPU data port (m0) and a secondary loader/debug master (m1).
- Sits between `openmips` and `data_ram` in the SOPC and drives the RAM control, address and data lines.
- Arbitration is round-robin; m1 may request a locked burst, bounded by a hold limit.
- Stalls the CPU through a stall request whenever m0 loses arbitration.

---
 rtl/data_ram_arbiter_pkg.sv | 17 +
 rtl/data_ram_arb_ctrl.sv | 65 ++++++
 rtl/data_ram_arbiter.sv | 77 +++++++
 tb/tb_data_ram_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_arbiter_pkg.sv
// Shared types and constants for the data RAM arbiter between the CPU data port and the loader/debug master.
package data_ram_arbiter_pkg;

   localparam int REG_BUS = 32;

   localparam logic CHIP_ENABLE   = 1'b1;
   localparam logic CHIP_DISABLE  = 1'b0;
   localparam logic WRITE_DISABLE = 1'b0;

   // Previous-cycle owner; encodings match ArbIdle / ArbM0 / ArbM1 in the SOPC defines.
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_M0   = 2'b01,
      S_M1   = 2'b10
   } owner_t;

endpackage

// File: rtl/data_ram_arb_ctrl.sv
// Round-robin grant logic with a bounded m1 lock: owner register, hold counter, grant decode.
//
// state  | meaning
// S_IDLE | nothing granted last cycle (also after reset)
// S_M0   | CPU data port granted last cycle
// S_M1   | loader/debug master granted last cycle
module data_ram_arb_ctrl
   import data_ram_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int HOLD_W   = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic m0_req,
   input  logic m1_req,
   input  logic m1_lock,
   output logic gnt_m0,
   output logic gnt_m1
);

   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

   owner_t owner, owner_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         owner    <= S_IDLE;
         hold_cnt <= '0;
      end else begin
         owner    <= owner_nxt;
         hold_cnt <= hold_nxt;
      end
   end

   always_comb begin
      owner_nxt = S_IDLE;
      if (gnt_m0)
         owner_nxt = S_M0;
      else if (gnt_m1)
         owner_nxt = S_M1;
      // hold only accumulates while m0 is actually waiting; an idle m0 leaves the lock unbounded
      hold_nxt = '0;
      if (gnt_m1 && m0_req)
         hold_nxt = (hold_cnt >= HOLD_MAX) ? HOLD_MAX : hold_cnt + 1'b1;
   end

   always_comb begin
      gnt_m0 = 1'b0;
      gnt_m1 = 1'b0;
      if (!rst) begin
         if (m0_req && m1_req) begin
            if (owner == S_M0 || (owner == S_M1 && m1_lock && hold_cnt < HOLD_MAX))
               gnt_m1 = 1'b1;
            else
               gnt_m0 = 1'b1;
         end else begin
            gnt_m0 = m0_req;
            gnt_m1 = m1_req;
         end
      end
   end

endmodule

// File: rtl/data_ram_arbiter.sv
// Shares the single-port data_ram between the CPU data port (m0) and a loader/debug master (m1).
module data_ram_arbiter
   import data_ram_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int HOLD_W   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               m0_ce_i,
   input  logic               m0_we_i,
   input  logic [REG_BUS-1:0] m0_addr_i,
   input  logic [3:0]         m0_sel_i,
   input  logic [REG_BUS-1:0] m0_data_i,
   output logic [REG_BUS-1:0] m0_data_o,
   output logic               m0_stall_o,
   input  logic               m1_req_i,
   input  logic               m1_we_i,
   input  logic [REG_BUS-1:0] m1_addr_i,
   input  logic [3:0]         m1_sel_i,
   input  logic [REG_BUS-1:0] m1_data_i,
   input  logic               m1_lock_i,
   output logic               m1_ack_o,
   output logic [REG_BUS-1:0] m1_data_o,
   output logic               ram_ce_o,
   output logic               ram_we_o,
   output logic [REG_BUS-1:0] ram_addr_o,
   output logic [3:0]         ram_sel_o,
   output logic [REG_BUS-1:0] ram_data_o,
   input  logic [REG_BUS-1:0] ram_data_i
);

   logic gnt_m0, gnt_m1;

   data_ram_arb_ctrl #(
      .MAX_HOLD (MAX_HOLD),
      .HOLD_W   (HOLD_W)
   ) u_ctrl (
      .clk     (clk),
      .rst     (rst),
      .m0_req  (m0_ce_i),
      .m1_req  (m1_req_i),
      .m1_lock (m1_lock_i),
      .gnt_m0  (gnt_m0),
      .gnt_m1  (gnt_m1)
   );

   // Grants are already zero during reset, so every output below collapses to 0 then.
   always_comb begin
      ram_ce_o   = CHIP_DISABLE;
      ram_we_o   = WRITE_DISABLE;
      ram_addr_o = '0;
      ram_sel_o  = '0;
      ram_data_o = '0;
      m0_data_o  = '0;
      m1_data_o  = '0;
      if (gnt_m0) begin
         ram_ce_o   = CHIP_ENABLE;
         ram_we_o   = m0_we_i;
         ram_addr_o = m0_addr_i;
         ram_sel_o  = m0_sel_i;
         ram_data_o = m0_data_i;
         m0_data_o  = ram_data_i;
      end else if (gnt_m1) begin
         ram_ce_o   = CHIP_ENABLE;
         ram_we_o   = m1_we_i;
         ram_addr_o = m1_addr_i;
         ram_sel_o  = m1_sel_i;
         ram_data_o = m1_data_i;
         m1_data_o  = ram_data_i;
      end
   end

   assign m0_stall_o = m0_ce_i & ~gnt_m0 & ~rst;
   assign m1_ack_o   = gnt_m1;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Self-checking bench: vector table, hand-written burst/reset sequences, randomized run against a reference model.
module tb_data_ram_arbiter;

   localparam int MAX_HOLD = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_ce_i, m0_we_i;
   logic [31:0] m0_addr_i, m0_data_i, m0_data_o;
   logic [3:0]  m0_sel_i;
   logic        m0_stall_o;
   logic        m1_req_i, m1_we_i, m1_lock_i, m1_ack_o;
   logic [31:0] m1_addr_i, m1_data_i, m1_data_o;
   logic [3:0]  m1_sel_i;
   logic        ram_ce_o, ram_we_o;
   logic [31:0] ram_addr_o, ram_data_o, ram_data_i;
   logic [3:0]  ram_sel_o;

   logic [31:0] mem [64];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   data_ram_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
      .clk(clk), .rst(rst),
      .m0_ce_i(m0_ce_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_sel_i(m0_sel_i),
      .m0_data_i(m0_data_i), .m0_data_o(m0_data_o), .m0_stall_o(m0_stall_o),
      .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_sel_i(m1_sel_i),
      .m1_data_i(m1_data_i), .m1_lock_i(m1_lock_i), .m1_ack_o(m1_ack_o), .m1_data_o(m1_data_o),
      .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_sel_o(ram_sel_o),
      .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
   );

   // Behavioural data_ram: combinational read, byte-masked write at posedge.
   assign ram_data_i = mem[ram_addr_o[7:2]];
   always @(posedge clk) begin
      if (ram_ce_o && ram_we_o)
         for (int b = 0; b < 4; b++)
            if (ram_sel_o[b]) mem[ram_addr_o[7:2]][b*8 +: 8] <= ram_data_o[b*8 +: 8];
   end

   typedef struct {
      logic        rst;
      logic        m0_ce;
      logic        m0_we;
      logic [31:0] m0_wdata;
      logic        m1_req;
      logic        m1_lock;
      int          exp_g;     // 0 none, 1 m0, 2 m1
      logic        chk_rd;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, exp);
      end
   endtask

   // Checks every output against the expected winner (0 none, 1 m0, 2 m1).
   task automatic check_outputs(input int g);
      chk("stall", 32'(m0_stall_o), 32'(m0_ce_i && !rst && g != 1));
      chk("ack", 32'(m1_ack_o), 32'(g == 2));
      chk("ram_ce", 32'(ram_ce_o), 32'(g != 0));
      chk("ram_we", 32'(ram_we_o), 32'(g == 1 ? m0_we_i : g == 2 ? m1_we_i : 1'b0));
      chk("ram_addr", ram_addr_o, g == 1 ? m0_addr_i : g == 2 ? m1_addr_i : 32'h0);
      chk("ram_sel", 32'(ram_sel_o), 32'(g == 1 ? m0_sel_i : g == 2 ? m1_sel_i : 4'h0));
      chk("ram_wdata", ram_data_o, g == 1 ? m0_data_i : g == 2 ? m1_data_i : 32'h0);
      chk("m0_rdata", m0_data_o, g == 1 ? mem[m0_addr_i[7:2]] : 32'h0);
      chk("m1_rdata", m1_data_o, g == 2 ? mem[m1_addr_i[7:2]] : 32'h0);
   endtask

   task automatic step(input logic r, input logic c0, input logic c1, input logic lk, input int g);
      rst = r; m0_ce_i = c0; m1_req_i = c1; m1_lock_i = lk;
      @(negedge clk);
      check_outputs(g);
      @(posedge clk); #1;
   endtask

   function automatic vec_t mk(logic r, logic c0, logic we, logic [31:0] wd, logic c1, logic lk,
                               int g, logic cr, logic [31:0] rd);
      vec_t v;
      v.rst = r; v.m0_ce = c0; v.m0_we = we; v.m0_wdata = wd;
      v.m1_req = c1; v.m1_lock = lk; v.exp_g = g; v.chk_rd = cr; v.exp_rd = rd;
      return v;
   endfunction

   // Reference model: previous winner and how long m1 has kept m0 waiting.
   int prev_win = 0;
   int wait_len = 0;

   function automatic int model_winner(logic c0, logic c1, logic lk);
      if (!c0 && !c1) return 0;
      if (c0 != c1) return c0 ? 1 : 2;
      if (prev_win == 1) return 2;
      if (prev_win == 2 && lk && wait_len < MAX_HOLD) return 2;
      return 1;
   endfunction

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      rst = 1'b1; m0_ce_i = 0; m0_we_i = 0; m0_addr_i = 32'h10; m0_sel_i = 4'hF; m0_data_i = 0;
      m1_req_i = 0; m1_we_i = 0; m1_addr_i = 32'h40; m1_sel_i = 4'h3; m1_data_i = 32'h1234;
      m1_lock_i = 0;
      @(posedge clk); #1;

      // ---- table-driven vectors (sequential: state carries across rows)
      vecs[0] = mk(1, 1, 0, 0,            1, 0, 0, 0, 0);
      vecs[1] = mk(0, 1, 0, 0,            1, 0, 1, 0, 0);
      vecs[2] = mk(0, 1, 0, 0,            1, 0, 2, 0, 0);
      vecs[3] = mk(0, 1, 0, 0,            1, 0, 1, 0, 0);
      vecs[4] = mk(0, 1, 0, 0,            1, 0, 2, 0, 0);
      vecs[5] = mk(1, 0, 0, 0,            0, 0, 0, 0, 0);
      vecs[6] = mk(0, 1, 1, 32'hDEADBEEF, 0, 0, 1, 0, 0);
      vecs[7] = mk(0, 1, 0, 0,            0, 0, 1, 1, 32'hDEADBEEF);
      vecs[8] = mk(0, 0, 0, 0,            1, 0, 2, 0, 0);
      vecs[9] = mk(0, 0, 0, 0,            0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         rst = vecs[i].rst; m0_ce_i = vecs[i].m0_ce; m0_we_i = vecs[i].m0_we;
         m0_data_i = vecs[i].m0_wdata; m1_req_i = vecs[i].m1_req; m1_lock_i = vecs[i].m1_lock;
         @(negedge clk);
         check_outputs(vecs[i].exp_g);
         if (vecs[i].chk_rd) chk("readback", m0_data_o, vecs[i].exp_rd);
         @(posedge clk); #1;
      end
      m0_we_i = 0; m0_data_i = 0;

      // ---- locked burst from S_M0: 8 m1 grants, 1 m0 grant, repeating
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 1);
      for (int i = 0; i < 27; i++) step(0, 1, 1, 1, (i % 9 < 8) ? 2 : 1);

      // ---- lock unbounded while m0 idle, then bounded once m0 waits
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) step(0, 0, 1, 1, 2);
      for (int i = 0; i < 9; i++) step(0, 1, 1, 1, (i < 8) ? 2 : 1);

      // ---- reset in burst cycle 3 drops the lock
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 1);
      step(0, 1, 1, 1, 2);
      step(0, 1, 1, 1, 2);
      step(1, 1, 1, 1, 0);
      step(0, 1, 1, 1, 1);
      step(0, 1, 1, 1, 2);

      // ---- randomized run against the reference model
      step(1, 0, 0, 0, 0);
      prev_win = 0; wait_len = 0;
      m1_req_i = 0;
      for (int n = 0; n < 600; n++) begin
         int  g;
         logic r;
         r = ($urandom_range(0, 39) == 0);
         m0_ce_i = ($urandom_range(0, 3) != 0);
         m0_we_i = $urandom_range(0, 1);
         m0_addr_i = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
         m0_sel_i = 4'($urandom_range(0, 15));
         m0_data_i = $urandom;
         if (!m1_req_i) begin
            m1_req_i = ($urandom_range(0, 2) != 0);
            m1_lock_i = ($urandom_range(0, 1) == 1);
            m1_we_i = $urandom_range(0, 1);
            m1_addr_i = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            m1_sel_i = 4'($urandom_range(0, 15));
            m1_data_i = $urandom;
         end
         rst = r;
         g = r ? 0 : model_winner(m0_ce_i, m1_req_i, m1_lock_i);
         @(negedge clk);
         check_outputs(g);
         @(posedge clk); #1;
         if (r) begin
            prev_win = 0; wait_len = 0;
            m1_req_i = 0;
         end else begin
            prev_win = g;
            wait_len = (g == 2 && m0_ce_i) ? ((wait_len + 1 > MAX_HOLD) ? MAX_HOLD : wait_len + 1) : 0;
            if (g == 2) m1_req_i = 0;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout t=%0t", $time);
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
